fifo_drain_stage: RTL and testbench
===================================

# fifo_drain_stage

Output stage directly downstream of the FIFO checked by the scoreboard. It pops the FIFO whenever it has room and holds popped words in a 2-entry elastic buffer. It presents them to the consumer on a valid/ready handshake. Its `pop` output is the FIFO `pop` that the scoreboard monitors, so pop never depends combinationally on consumer `out_rdy`.

## Interface
- `WIDTH`, `` `FIFO_DWIDTH ``, data word width (matches FIFO `data_out`)
- `SCW`, 16, stall counter width (used only with `STALL_CNT_EN`)

One clock; reset is synchronous and active-high.

- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `empty`  in  1  FIFO empty flag
- `fifo_data`  in  WIDTH  FIFO head word (FIFO `data_out`, valid when `~empty`)
- `pop`  out  1  FIFO pop; head word captured same cycle
- `out_vld`  out  1  `out_data` valid
- `out_rdy`  in  1  consumer accepts when `out_vld & out_rdy`
- `out_data`  out  WIDTH  oldest buffered word
- `stall_cnt`  out  SCW  stall cycles seen (port exists only with `STALL_CNT_EN`)

## Operation
- State is the registered occupancy `occ`, one of EMPTY=0, ONE=1 or FULL=2. Storage is `ent0` (head) and `ent1`.
- `pop = ~rst & ~empty & (occ != FULL)`. This is purely from registered state and `empty`.
- `out_vld = (occ != EMPTY)` and `out_data = ent0`.
- `deq = out_vld & out_rdy`.
- Transitions:
  - EMPTY: if `pop`, `ent0<=fifo_data` and go to ONE.
  - ONE:
    - `pop & deq`: `ent0<=fifo_data`, stay ONE.
    - `pop & ~deq`: `ent1<=fifo_data`, go to FULL.
    - `~pop & deq`: go to EMPTY.
    - otherwise hold.
  - FULL (`pop` is 0 here):
    - `deq`: `ent0<=ent1`, go to ONE.
    - otherwise hold.
- Order is strict FIFO. No word is dropped or duplicated.
- Reset mid-operation: `occ<=EMPTY`. Buffered words are discarded; the FIFO resets in the same cycle. `pop` is 0 during any cycle with `rst` high.
- Data registers need no reset. `out_data` is don't-care while `out_vld=0`.

## Timing
- Reset values: `out_vld=0`, `pop=0` (while `rst` high), `stall_cnt=0`.
- Latency from FIFO pop to `out_vld`: 1 cycle.
- Throughput: 1 word/cycle with `out_rdy` held high. Steady state is ONE, with `pop` and `deq` every cycle.
- Backpressure: after `out_rdy` drops, at most one further pop occurs (ONE→FULL). Pops then stop until a `deq`.
- Once `out_vld` is high, `out_data` is stable until `deq`.
- `out_vld` falls only after a `deq` with no refill.
- Simultaneous `pop` and `deq` in ONE: the new word replaces the head on the same edge; no bubble.

## Configuration
- `STALL_CNT_EN` defined:
  - `stall_cnt` increments on each cycle with `out_vld & ~out_rdy`.
  - It saturates at `2**SCW-1` and clears on `rst`.
- `STALL_CNT_EN` undefined: no `stall_cnt` port, counter or logic. Datapath behaviour is identical in both builds.

## Structure
- Shared package `drain_pkg` holds:
  - the occupancy encoding constants: `OCC_EMPTY=2'd0`, `OCC_ONE=2'd1`, `OCC_FULL=2'd2`;
  - the `SCW` default.
- `WIDTH` default comes from `` `FIFO_DWIDTH `` in options.
- Registers are instances of the existing `FF` utility: `occ`, `ent0` and `ent1` each get one, with explicit enables.
- No new sub-module is needed. Entry storage and steering stay in this module, and the stall counter sits in a `` `ifdef STALL_CNT_EN `` block.

## Test plan
- Reset then drain: FIFO preloaded with 3,5,7 and `out_rdy=1`.
  - `pop` high for 3 consecutive cycles.
  - `out_data` is 3,5,7 on the following 3 cycles, then `out_vld=0`.
- Backpressure: words 1..4 available and `out_rdy=0` from cycle 0.
  - Exactly 2 pops, then `occ=FULL`, `pop=0`, `out_data=1` held.
  - Raise `out_rdy`: outputs 1,2,3,4 in order.
- Empty FIFO: `empty=1` throughout.
  - `pop` never asserts and `out_vld` stays 0.
  - No X appears on `pop`.
- Simultaneous: in ONE holding 9, `out_rdy=1`, FIFO head 10.
  - Next cycle `out_data=10` and `occ=ONE`.
  - 9 is delivered exactly once.
- Reset mid-stream: in FULL (8,9), assert `rst` for 1 cycle.
  - Next cycle `out_vld=0` and `pop=0` during reset.
  - Neither 8 nor 9 is emitted afterwards.
- `STALL_CNT_EN`: `out_vld=1` with `out_rdy=0` for 5 cycles gives `stall_cnt=5`. With `SCW=2`, 6 stall cycles give `stall_cnt=3` (saturated).

Source files
------------

// File: rtl/drain_pkg.sv
// Shared constants for the FIFO drain stage: occupancy encoding and counter width default.
`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 32
`endif

package drain_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  localparam int SCW_DEFAULT = 16;

endpackage

// File: rtl/fifo_drain_stage_if.sv
// FIFO-side pop interface plus consumer-side valid/ready bus of the drain stage.
interface fifo_drain_stage_if #(
  parameter int WIDTH = `FIFO_DWIDTH
);
  logic             empty;
  logic [WIDTH-1:0] fifo_data;
  logic             pop;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  empty, fifo_data, out_rdy,
    output pop, out_vld, out_data
  );

  modport slave (
    output empty, fifo_data, out_rdy,
    input  pop, out_vld, out_data
  );
endinterface

// File: rtl/ff.sv
// Generic enabled register; optional synchronous active-high reset (RST_EN) to RST_VAL.
module FF #(
  parameter int           W       = 1,
  parameter bit           RST_EN  = 1'b0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (RST_EN && rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fifo_drain_stage.sv
// FIFO drain stage: pops FIFO into a 2-entry elastic buffer, 1 cycle pop->out_vld, pop stops when full.
// Optional stall counter under `STALL_CNT_EN; pop never depends combinationally on out_rdy.
module fifo_drain_stage
  import drain_pkg::*;
#(
  parameter int WIDTH = `FIFO_DWIDTH
`ifdef STALL_CNT_EN
  , parameter int SCW = SCW_DEFAULT
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_drain_stage_if.master     bus
`ifdef STALL_CNT_EN
  , output logic [SCW-1:0]       stall_cnt
`endif
);

  occ_t             occ_q;
  occ_t             occ_d;
  logic             occ_en;
  logic [WIDTH-1:0] ent0_q;
  logic [WIDTH-1:0] ent0_d;
  logic             ent0_en;
  logic [WIDTH-1:0] ent1_q;
  logic             ent1_en;
  logic             pop;
  logic             vld;
  logic             deq;

  assign pop = ~rst & ~bus.empty & (occ_q != OCC_FULL);
  assign vld = (occ_q != OCC_EMPTY);
  assign deq = vld & bus.out_rdy;

  assign bus.pop      = pop;
  assign bus.out_vld  = vld;
  assign bus.out_data = ent0_q;

  always_comb begin
    occ_d   = occ_q;
    ent0_d  = bus.fifo_data;
    ent0_en = 1'b0;
    ent1_en = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (pop) begin
          ent0_en = 1'b1;
          occ_d   = OCC_ONE;
        end
      end
      OCC_ONE: begin
        // Refill and dequeue on the same edge: new word replaces head, no bubble.
        if (pop && deq) begin
          ent0_en = 1'b1;
        end else if (pop) begin
          ent1_en = 1'b1;
          occ_d   = OCC_FULL;
        end else if (deq) begin
          occ_d   = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (deq) begin
          ent0_d  = ent1_q;
          ent0_en = 1'b1;
          occ_d   = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  assign occ_en = (occ_d != occ_q);

  FF #(.W(2), .RST_EN(1'b1), .RST_VAL(OCC_EMPTY)) u_occ (
    .clk (clk),
    .rst (rst),
    .en  (occ_en),
    .d   (occ_d),
    .q   (occ_q)
  );

  FF #(.W(WIDTH)) u_ent0 (
    .clk (clk),
    .rst (rst),
    .en  (ent0_en),
    .d   (ent0_d),
    .q   (ent0_q)
  );

  FF #(.W(WIDTH)) u_ent1 (
    .clk (clk),
    .rst (rst),
    .en  (ent1_en),
    .d   (bus.fifo_data),
    .q   (ent1_q)
  );

`ifdef STALL_CNT_EN
  logic [SCW-1:0] stall_q;

  // Saturating count of cycles where a word waits on the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (vld && !bus.out_rdy && (stall_q != {SCW{1'b1}})) begin
      stall_q <= stall_q + SCW'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_drain_stage.sv
// Scoreboard bench for fifo_drain_stage: emulated source FIFO, word-order queue and occupancy-count model.
module tb_fifo_drain_stage;

  localparam int W = 8;
`ifdef STALL_CNT_EN
  localparam int SCW = 3;
  logic [SCW-1:0] stall_cnt;
  int stall_exp = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_drain_stage_if #(.WIDTH(W)) bus ();

  fifo_drain_stage #(
    .WIDTH(W)
`ifdef STALL_CNT_EN
    , .SCW(SCW)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_q[$];
  int           stage_cnt = 0;
  int           checks = 0;
  int           errors = 0;
  int           pop_total = 0;
  bit           pend_pop = 1'b0;
  bit           held_vld = 1'b0;
  logic [W-1:0] held_data;
  logic         exp_pop;
  bit           deq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_src();
    bus.empty     = (src_q.size() == 0);
    bus.fifo_data = (src_q.size() == 0) ? '0 : src_q[0];
  endtask

  task automatic push(input logic [W-1:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
    drive_src();
  endtask

  // Advance one clock; the emulated FIFO retires its head if the stage popped it.
  task automatic step();
    @(posedge clk);
    #1;
    if (pend_pop && src_q.size() > 0) void'(src_q.pop_front());
    pend_pop = 1'b0;
    drive_src();
  endtask

  task automatic do_reset();
    bus.out_rdy = 1'b0;
    rst = 1'b1;
    src_q.delete();
    exp_q.delete();
    drive_src();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || stage_cnt != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", (exp_q.size() == 0 && stage_cnt == 0), 1);
  endtask

  // Monitor: stage holds pops minus deqs words (at most 2); words leave in push order.
  always @(negedge clk) begin
    exp_pop = !rst && (src_q.size() > 0) && (stage_cnt < 2);
    chk("pop", bus.pop, exp_pop);
    chk("out_vld", bus.out_vld, stage_cnt > 0);
    if (held_vld) chk("hold_data", bus.out_data, held_data);
    deq = (bus.out_vld === 1'b1) && (bus.out_rdy === 1'b1);
    if (deq) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0h expected=none at %0t", bus.out_data, $time);
      end else begin
        chk("out_data", bus.out_data, exp_q.pop_front());
      end
    end
`ifdef STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stall_exp);
    if (rst) stall_exp = 0;
    else if (bus.out_vld === 1'b1 && bus.out_rdy !== 1'b1 && stall_exp < (2**SCW - 1)) stall_exp++;
`endif
    held_vld  = !rst && (bus.out_vld === 1'b1) && (bus.out_rdy !== 1'b1);
    held_data = bus.out_data;
    if (bus.pop === 1'b1) pop_total++;
    pend_pop  = (bus.pop === 1'b1);
    if (rst) stage_cnt = 0;
    else stage_cnt = stage_cnt + int'(bus.pop === 1'b1) - int'(deq);
  end

  initial begin
    int p0;
    bus.out_rdy = 1'b1;
    drive_src();

    // Reset, then drain a preloaded 3,5,7 at full rate.
    push(8'd3); push(8'd5); push(8'd7);
    step(); step();
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_pop", bus.pop, 0);
    rst = 1'b0;
    p0 = pop_total;
    step(); step(); step();
    chk("drain_pops", pop_total - p0, 3);
    wait_drain(10);

    // Backpressure: words 1..4, consumer not ready.
    bus.out_rdy = 1'b0;
    p0 = pop_total;
    for (int i = 1; i <= 4; i++) push(W'(i));
    for (int i = 0; i < 5; i++) step();
    chk("bp_pops", pop_total - p0, 2);
    chk("bp_head", bus.out_data, 1);
    chk("bp_pop_low", bus.pop, 0);
    bus.out_rdy = 1'b1;
    wait_drain(20);

    // Empty FIFO: nothing must be popped or presented.
    for (int i = 0; i < 10; i++) begin
      bus.out_rdy = 1'($urandom_range(0, 1));
      step();
    end

    // Simultaneous pop and deq while holding 9.
    bus.out_rdy = 1'b0;
    push(8'd9);
    step();
    push(8'd10);
    bus.out_rdy = 1'b1;
    step();
    chk("simul_vld", bus.out_vld, 1);
    chk("simul_data", bus.out_data, 10);
    wait_drain(10);

    // Reset while FULL with 8,9: neither may appear afterwards.
    bus.out_rdy = 1'b0;
    push(8'd8); push(8'd9);
    step(); step(); step();
    chk("full_head", bus.out_data, 8);
    do_reset();
    chk("post_rst_vld", bus.out_vld, 0);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Random traffic with occasional mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        if (src_q.size() < 6 && $urandom_range(0, 2) != 0) push(W'($urandom));
        bus.out_rdy = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    bus.out_rdy = 1'b1;
    wait_drain(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
